// File: rtl/flit_input_buffer.sv
// Input flit FIFO with write-side head/body tagging and front-entry decode.
// Optional protocol error flag enabled by FLIT_INPUT_BUFFER_ERR_EN.
module flit_input_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADD_WIDTH  = 8,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [FLIT_WIDTH-1:0]     flit_i,
  output logic                      full_o,
  input  logic                      pop_i,
  output logic [FLIT_WIDTH-1:0]     flit_o,
  output logic                      empty_o,
  output logic                      head_valid_o,
  output logic [ADD_WIDTH-1:0]      flit_length_o,
  output logic [7:0]                flit_address_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [ADD_WIDTH-1:0] LEN_ONE = ADD_WIDTH'(1);

  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_head;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [ADD_WIDTH-1:0]  r_wr_rem;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_is_head;
  logic [ADD_WIDTH-1:0]  w_len;
  logic [ADD_WIDTH-1:0]  w_rem_nxt;
  logic [FLIT_WIDTH-1:0] w_front;
  logic                  w_front_head;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = push_i && !w_full;
  assign w_pop     = pop_i && !w_empty;
  assign w_is_head = (r_wr_rem == '0);
  assign w_len     = flit_i[ADD_WIDTH+7:8];

  // A zero length field still describes a one-flit packet.
  always_comb begin
    w_rem_nxt = r_wr_rem;
    if (w_is_head) begin
      w_rem_nxt = (w_len == '0) ? '0 : w_len - LEN_ONE;
    end else begin
      w_rem_nxt = r_wr_rem - LEN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_rem <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_wr_rem <= w_rem_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]  <= flit_i;
      r_head[r_wr_ptr] <= w_is_head;
    end
  end

  assign w_front      = r_mem[r_rd_ptr];
  assign w_front_head = r_head[r_rd_ptr];

  assign flit_o         = w_empty ? '0 : w_front;
  assign head_valid_o   = !w_empty && w_front_head;
  assign flit_length_o  = head_valid_o ? w_front[ADD_WIDTH+7:8] : '0;
  assign flit_address_o = head_valid_o ? w_front[7:0] : '0;
  assign count_o        = r_count;
  assign full_o         = w_full;
  assign empty_o        = w_empty;

`ifdef FLIT_INPUT_BUFFER_ERR_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = (push_i && w_full)
                   || (pop_i && w_empty)
                   || (w_push && w_is_head && (w_len == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_flit_input_buffer.sv
// Scoreboard bench for flit_input_buffer against a queue-based packet model.
// Directed scenarios followed by randomized push/pop/reset traffic.
module tb_flit_input_buffer;

  localparam int FW = 32;
  localparam int AW = 8;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push_i = 1'b0;
  logic          pop_i = 1'b0;
  logic [FW-1:0] flit_i = '0;
  logic          full_o;
  logic [FW-1:0] flit_o;
  logic          empty_o;
  logic          head_valid_o;
  logic [AW-1:0] flit_length_o;
  logic [7:0]    flit_address_o;
  logic [3:0]    count_o;
  logic          err_o;

  flit_input_buffer #(.FLIT_WIDTH(FW), .ADD_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .push_i(push_i),
    .flit_i(flit_i),
    .full_o(full_o),
    .pop_i(pop_i),
    .flit_o(flit_o),
    .empty_o(empty_o),
    .head_valid_o(head_valid_o),
    .flit_length_o(flit_length_o),
    .flit_address_o(flit_address_o),
    .count_o(count_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] data;
    logic          head;
  } ent_t;

  ent_t mq[$];
  ent_t exp_q[$];
  int   pkt_left = 0;
  bit   m_err = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] mk(input int addr, input int len);
    logic [FW-1:0] r;
    r = $urandom;
    r[AW+7:8] = len[AW-1:0];
    r[7:0] = addr[7:0];
    return r;
  endfunction

  // Monitor: every cycle the DUT presents a flit being popped, compare it.
  always @(negedge clk) begin
    if (reset && pop_i && !empty_o) begin
      chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_flit", 64'(flit_o), 64'(e.data));
        chk("pop_head", 64'(head_valid_o), 64'(e.head));
      end
    end
  end

  task automatic cyc(input bit rst_n, input bit p, input logic [FW-1:0] f,
                     input bit q);
    int len;
    bit acc;
    reset = rst_n;
    push_i = p;
    flit_i = f;
    pop_i = q;
    if (rst_n && q && mq.size() > 0) exp_q.push_back(mq[0]);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      pkt_left = 0;
      m_err = 1'b0;
    end else begin
      acc = p && (mq.size() < D);
      len = int'(f[AW+7:8]);
`ifdef FLIT_INPUT_BUFFER_ERR_EN
      if (p && mq.size() == D) m_err = 1'b1;
      if (q && mq.size() == 0) m_err = 1'b1;
      if (acc && pkt_left == 0 && len == 0) m_err = 1'b1;
`endif
      if (q && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        ent_t e;
        e.data = f;
        e.head = (pkt_left == 0);
        if (e.head) pkt_left = (len == 0) ? 0 : len - 1;
        else pkt_left--;
        mq.push_back(e);
      end
    end
    #1;
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0));
    chk("full", 64'(full_o), 64'(mq.size() == D));
    chk("err", 64'(err_o), 64'(m_err));
    if (mq.size() == 0) begin
      chk("flit_o", 64'(flit_o), 64'd0);
      chk("head_valid", 64'(head_valid_o), 64'd0);
      chk("length", 64'(flit_length_o), 64'd0);
      chk("address", 64'(flit_address_o), 64'd0);
    end else begin
      chk("flit_o", 64'(flit_o), 64'(mq[0].data));
      chk("head_valid", 64'(head_valid_o), 64'(mq[0].head));
      chk("length", 64'(flit_length_o),
          mq[0].head ? 64'(mq[0].data[AW+7:8]) : 64'd0);
      chk("address", 64'(flit_address_o),
          mq[0].head ? 64'(mq[0].data[7:0]) : 64'd0);
    end
  endtask

  task automatic push(input logic [FW-1:0] f);
    cyc(1, 1, f, 0);
  endtask

  task automatic pop();
    cyc(1, 0, $urandom, 1);
  endtask

  task automatic rst();
    cyc(0, 0, '0, 0);
  endtask

  initial begin
    rst();
    rst();
    cyc(1, 0, '0, 0);

    push(mk(8'h5A, 3));
    push($urandom);
    push($urandom);
    chk("pkt3_addr", 64'(flit_address_o), 64'h5A);
    chk("pkt3_len", 64'(flit_length_o), 64'd3);
    repeat (3) pop();

    for (int i = 0; i < 8; i++) push(mk(i, 1));
    push(mk(8'h99, 1));
    chk("fill_count", 64'(count_o), 64'd8);
    repeat (4) pop();
    for (int i = 8; i < 12; i++) push(mk(i, 1));
    repeat (8) pop();
    pop();
    rst();

    for (int i = 0; i < 3; i++) push(mk(i, 1));
    for (int i = 3; i < 8; i++) cyc(1, 1, mk(i, 1), 1);
    for (int i = 8; i < 13; i++) push(mk(i, 1));
    cyc(1, 1, mk(8'hEE, 1), 1);
    chk("full_pushpop_count", 64'(count_o), 64'd7);
    repeat (7) pop();
    rst();

    push(mk(8'h01, 4));
    push($urandom);
    rst();
    push(mk(8'h11, 2));
    chk("midpkt_addr", 64'(flit_address_o), 64'h11);
    pop();
    rst();

    push(mk(8'h33, 0));
    push(mk(8'h22, 1));
    pop();
    chk("zero_len_next_addr", 64'(flit_address_o), 64'h22);
    pop();
    rst();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst();
      end else begin
        cyc(1, $urandom_range(0, 9) < 6, mk($urandom_range(0, 255),
            $urandom_range(0, 4)), $urandom_range(0, 9) < 5);
      end
    end
    while (mq.size() > 0) pop();
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
